uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
Reader-side consumer for the single-clock TX FIFO. It pops bytes from the FIFO's pop/empty/dout port and serialises each byte as an 8N1 or 8N2 UART frame on `tx`. It sits between the CPU-written TX FIFO and the UART pin. It uses the FIFO's combinational read port: `fifo_dout` is valid whenever `fifo_empty` is 0 and advances on the clock edge after `fifo_pop`.

Parameters:
DATA_WIDTH, 8, bits per frame; LSB sent first.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
DIV_WIDTH, 16, width of the baud divisor input.

Ports:
clk  input  1  system clock.
resetn  input  1  asynchronous, active-low reset; one clock domain only.
enable  input  1  when 0, no new frame starts; a frame in flight completes.
div  input  DIV_WIDTH  clocks per bit; 0 is treated as 1; sampled only at frame start.
fifo_dout  input  DATA_WIDTH  FIFO head data; valid while fifo_empty=0.
fifo_empty  input  1  FIFO empty flag.
fifo_pop  output  1  one-cycle pop strobe to the FIFO.
tx  output  1  serial line; idles high.
busy  output  1  high from frame start until the last stop-bit cycle ends.

Behaviour:
- Reset (async assert): `tx`=1, `fifo_pop`=0, `busy`=0, state=IDLE, bit counter=0, baud counter=0. The outputs change immediately on assertion, not at the next clock edge.
- Reset mid-frame: the frame is abandoned and the line returns high at once. The popped byte is lost; the FIFO is not rewound.
- States and transitions:
  - IDLE → START.
  - START → DATA.
  - DATA → STOP.
  - STOP → IDLE, or STOP → START when another byte is ready.
- Launch condition: state is IDLE, or state is STOP in its final cycle, and `enable`=1 and `fifo_empty`=0.
- On the launch cycle:
  - `fifo_pop`=1 for exactly that cycle.
  - `fifo_dout` is latched into the shift register.
  - `div` is latched as `per` = max(div,1).
  - Next state is START.
- Latency: `fifo_pop` is asserted in cycle N; `tx` falls in cycle N+1 (registered output).
- Bit timing:
  - Every bit (start, each data bit, each stop bit) lasts exactly `per` clocks.
  - The baud counter counts 0..per-1; the bit ends when the count reaches per-1.
- START: `tx`=0 for one bit period.
- DATA: `tx` = shift[0]; shift right at each bit end. After DATA_WIDTH bits, go to STOP.
- STOP: `tx`=1 for STOP_BITS bit periods.
- End of STOP:
  - If the launch condition holds, go straight to START. Back-to-back frames have zero idle cycles.
  - Otherwise go to IDLE.
- `busy`:
  - Rises in the cycle after the pop.
  - Falls in the cycle after the last stop-bit clock, unless a back-to-back frame launches.
  - `busy`=0 only in IDLE.
- `fifo_pop` is never asserted while `fifo_empty`=1, and never more than once per frame.
- The FIFO full/push side is not touched.
- Changing `div` mid-frame has no effect until the next launch.
- Deasserting `enable` mid-frame has no effect on that frame.
- Width rules:
  - Baud counter width is DIV_WIDTH.
  - Bit counter width is $clog2(DATA_WIDTH+1).
  - Frame length = (1 + DATA_WIDTH + STOP_BITS) × per clocks.

Decomposition:
- Shared package `uart_pkg`:
  - State encoding localparams: ST_IDLE, ST_START, ST_DATA, ST_STOP.
  - UART_DATA_WIDTH=8.
  - Default divisor constant.
  - The same encodings are to be reused by the RX side.
- One sub-module: `uart_baud_cnt`.
  - Loadable down/up counter with async reset.
  - Inputs: `clear`, `per`. Output: one-cycle `bit_end`.
  - Instantiated once here; the RX block reuses it.

Test Plan:
- Byte 0xA5 in FIFO, div=4, enable=1:
  - Pop at cycle N.
  - `tx`=0 over cycles N+1..N+4.
  - Data bits 1,0,1,0,0,1,0,1, each held 4 clocks.
  - Stop bit high for 4 clocks.
  - `busy` high for 40 clocks, then low.
  - Exactly one pop.
- Two bytes 0x00 then 0xFF, div=2:
  - Second pop occurs in the final stop cycle of frame 1.
  - Start bit of frame 2 immediately follows; `busy` never drops.
  - Total 40 clocks.
- FIFO empty, enable=1 for 100 clocks: `fifo_pop`=0, `tx`=1, `busy`=0 throughout.
- div=0, byte 0x55: each bit lasts 1 clock; frame is exactly 10 clocks; `tx` toggles 0,1,0,1,0,1,0,1,0,1.
- resetn pulsed low at data bit 3 of a 0x3C frame, div=8:
  - `tx`=1 and `busy`=0 asynchronously, before the next clk edge.
  - After release, the next FIFO byte is sent as a clean full frame.
- STOP_BITS=2 build, div=3, and `div` changed to 10 mid-frame:
  - Current frame keeps 3-clock bits, with a 6-clock stop.
  - Next frame uses 10-clock bits.
  - enable=0 mid-frame: current frame completes and no further pop occurs.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-engine state encoding and default constants,
// common to the TX drain and the RX side.
package uart_pkg;

  localparam int          UART_DATA_WIDTH = 8;
  localparam int          UART_DIV_WIDTH  = 16;
  localparam logic [15:0] UART_DEF_DIV    = 16'd16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..per-1 and flags the last clock of each bit.
// Held at zero while clear is high so the first bit after clear is a full period.
module uart_baud_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic [W-1:0] per,
  output logic         bit_end
);

  logic [W-1:0] cnt;
  logic [W-1:0] last;

  // A zero period behaves like a one-clock period.
  assign last    = (per == '0) ? '0 : per - W'(1);
  assign bit_end = !clear && (cnt == last);

  // Count up, wrap to zero at the end of every bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                cnt <= '0;
    else if (clear || bit_end)  cnt <= '0;
    else                        cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from a show-ahead TX FIFO and serialises each one as an
// 8N1/8N2 UART frame. Back-to-back frames launch in the final stop cycle.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int STOP_BITS  = 1,
  parameter int DIV_WIDTH  = UART_DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  uart_state_e           state, state_d;
  logic [DATA_WIDTH-1:0] shift, shift_d;
  logic [DIV_WIDTH-1:0]  per, per_d;
  logic [BCW-1:0]        bcnt, bcnt_d;
  logic                  tx_d;
  logic                  bit_end;
  logic                  stop_last;
  logic                  launch;

  uart_baud_cnt #(.W(DIV_WIDTH)) u_baud (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (state == ST_IDLE),
    .per     (per),
    .bit_end (bit_end)
  );

  assign stop_last = (state == ST_STOP) && bit_end && (bcnt == BCW'(STOP_BITS - 1));
  assign launch    = ((state == ST_IDLE) || stop_last) && enable && !fifo_empty;
  // Gated by reset so the FIFO never loses a byte while the block is held in reset.
  assign fifo_pop  = launch && resetn;
  assign busy      = (state != ST_IDLE);

  // Next-state, datapath loads and registered line value.
  always_comb begin
    state_d = state;
    shift_d = shift;
    per_d   = per;
    bcnt_d  = bcnt;
    case (state)
      ST_START: if (bit_end) begin
        state_d = ST_DATA;
        bcnt_d  = '0;
      end
      ST_DATA: if (bit_end) begin
        shift_d = shift >> 1;
        if (bcnt == BCW'(DATA_WIDTH - 1)) begin
          state_d = ST_STOP;
          bcnt_d  = '0;
        end else begin
          bcnt_d  = bcnt + BCW'(1);
        end
      end
      ST_STOP: if (bit_end) begin
        if (stop_last) begin
          state_d = ST_IDLE;
          bcnt_d  = '0;
        end else begin
          bcnt_d  = bcnt + BCW'(1);
        end
      end
      default: ;
    endcase
    if (launch) begin
      state_d = ST_START;
      shift_d = fifo_dout;
      per_d   = (div == '0) ? DIV_WIDTH'(1) : div;
      bcnt_d  = '0;
    end
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // State, datapath and line registers; reset forces the line idle at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      shift <= '0;
      per   <= DIV_WIDTH'(UART_DEF_DIV);
      bcnt  <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_d;
      shift <= shift_d;
      per   <= per_d;
      bcnt  <= bcnt_d;
      tx    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench: two DUTs (1 and 2 stop bits), each fed by a bench-side FIFO, checked
// every cycle against a frame-level model plus directed literal expectations.
module tb_uart_tx_fifo_drain;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  en;
  logic [15:0] div_v [2];
  logic [7:0]  fifo_dout [2];
  logic [1:0]  fifo_empty;
  logic [1:0]  pop, tx, busy;

  logic [7:0]  fmem [2][256];
  int          wp [2] = '{0, 0};
  int          rp [2] = '{0, 0};

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .STOP_BITS(1), .DIV_WIDTH(16)) u_dut0 (
    .clk(clk), .resetn(resetn), .enable(en[0]), .div(div_v[0]),
    .fifo_dout(fifo_dout[0]), .fifo_empty(fifo_empty[0]),
    .fifo_pop(pop[0]), .tx(tx[0]), .busy(busy[0]));

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .STOP_BITS(2), .DIV_WIDTH(16)) u_dut1 (
    .clk(clk), .resetn(resetn), .enable(en[1]), .div(div_v[1]),
    .fifo_dout(fifo_dout[1]), .fifo_empty(fifo_empty[1]),
    .fifo_pop(pop[1]), .tx(tx[1]), .busy(busy[1]));

  // Show-ahead FIFO read port.
  always_comb begin
    fifo_empty = '1;
    for (int i = 0; i < 2; i++) begin
      fifo_dout[i]  = fmem[i][rp[i] & 255];
      fifo_empty[i] = (wp[i] == rp[i]);
    end
  end

  // FIFO advances on the edge after a pop.
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (pop[i] && !fifo_empty[i]) rp[i] <= rp[i] + 1;

  task automatic chk(input string nm, input int ln, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s lane%0d cycle %0d: got %0h expected %0h", nm, ln, cyc, act, exp);
    end
  endtask

  task automatic push(input int ln, input logic [7:0] b);
    fmem[ln][wp[ln] & 255] = b;
    wp[ln] = wp[ln] + 1;
  endtask

  function automatic int sbits(input int ln);
    return (ln == 0) ? 1 : 2;
  endfunction

  // Frame-level model: each frame is a list of (1 + 8 + stop) bits, each
  // `per` clocks long; a new frame may start on the last clock of the old one.
  bit         m_act  [2] = '{0, 0};
  int         m_t    [2] = '{0, 0};
  int         m_per  [2] = '{1, 1};
  logic [7:0] m_byte [2];

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int  len, b;
        bit  lau, e_tx;
        if (!resetn) begin
          m_act[i] = 0;
          chk("m_rst_tx", i, int'(tx[i]), 1);
          chk("m_rst_busy", i, int'(busy[i]), 0);
          chk("m_rst_pop", i, int'(pop[i]), 0);
        end else begin
          len  = m_per[i] * (9 + sbits(i));
          lau  = (!m_act[i] || m_t[i] == len - 1) && en[i] && (wp[i] != rp[i]);
          e_tx = 1'b1;
          if (m_act[i]) begin
            b = m_t[i] / m_per[i];
            if (b == 0)      e_tx = 1'b0;
            else if (b <= 8) e_tx = m_byte[i][b-1];
          end
          chk("m_tx", i, int'(tx[i]), int'(e_tx));
          chk("m_busy", i, int'(busy[i]), int'(m_act[i]));
          chk("m_pop", i, int'(pop[i]), int'(lau));
          if (m_act[i]) begin
            m_t[i]++;
            if (m_t[i] == len) m_act[i] = 0;
          end
          if (lau) begin
            m_act[i]  = 1;
            m_t[i]    = 0;
            m_byte[i] = fmem[i][rp[i] & 255];
            m_per[i]  = (div_v[i] == 0) ? 1 : int'(div_v[i]);
          end
        end
      end
    end
  end

  task automatic wait_pop(input int ln, input int maxc, output bit ok);
    ok = 0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (pop[ln]) begin ok = 1; break; end
    end
    if (!ok) chk("wait_pop_timeout", ln, 0, 1);
  endtask

  // Lane-0 frame against a literal 10-bit line pattern (bit 0 = start bit).
  task automatic check_frame(input string nm, input logic [9:0] pat, input int per);
    bit ok;
    wait_pop(0, 50, ok);
    if (ok) begin
      for (int k = 0; k < 10 * per; k++) begin
        @(negedge clk);
        chk({nm, "_tx"}, 0, int'(tx[0]), int'(pat[k / per]));
        chk({nm, "_busy"}, 0, int'(busy[0]), 1);
        chk({nm, "_pop"}, 0, int'(pop[0]), 0);
      end
      @(negedge clk);
      chk({nm, "_busy_end"}, 0, int'(busy[0]), 0);
    end
  endtask

  initial begin
    bit ok;
    int p2, bc, np;
    resetn   = 1'b0;
    en       = 2'b00;
    div_v[0] = 16'd4;
    div_v[1] = 16'd3;
    #12;
    chk("rst_tx", 0, int'(tx), 3);
    chk("rst_busy", 0, int'(busy), 0);
    chk("rst_pop", 0, int'(pop), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // 0xA5 at div 4: 40-clock frame.
    push(0, 8'hA5);
    en[0] = 1'b1;
    check_frame("a5", 10'b1_1010_0101_0, 4);

    // Empty FIFOs with enable high.
    @(posedge clk); #1 en = 2'b11;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      chk("empty_pop", 0, int'(pop), 0);
      chk("empty_tx", 0, int'(tx), 3);
      chk("empty_busy", 0, int'(busy), 0);
    end
    @(posedge clk); #1 en[1] = 1'b0;

    // 0x00 then 0xFF at div 2: back-to-back, second pop in final stop cycle.
    div_v[0] = 16'd2;
    push(0, 8'h00);
    push(0, 8'hFF);
    wait_pop(0, 20, ok);
    p2 = -1; bc = 0;
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      if (pop[0] && p2 < 0) p2 = k;
      if (!busy[0]) break;
      bc++;
    end
    chk("b2b_pop2_offset", 0, p2, 20);
    chk("b2b_busy_len", 0, bc, 40);

    // div 0 behaves as 1: ten 1-clock bits.
    @(posedge clk); #1 div_v[0] = 16'd0;
    push(0, 8'h55);
    check_frame("div0", 10'b1_0101_0101_0, 1);

    // Reset in data bit 3 of 0x3C, then 0x81 goes out as a clean frame.
    @(posedge clk); #1 div_v[0] = 16'd8;
    push(0, 8'h3C);
    push(0, 8'h81);
    wait_pop(0, 20, ok);
    repeat (33) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_tx", 0, int'(tx[0]), 1);
    chk("async_rst_busy", 0, int'(busy[0]), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    check_frame("post_rst", 10'b1_1000_0001_0, 8);

    // Two stop bits, div 3 -> 10 mid-frame, enable dropped in frame 2.
    @(posedge clk); #1;
    div_v[1] = 16'd3;
    push(1, 8'h5A);
    push(1, 8'hC3);
    push(1, 8'h11);
    en[1] = 1'b1;
    wait_pop(1, 20, ok);
    p2 = -1; bc = 0; np = 0;
    for (int k = 1; k < 200; k++) begin
      @(posedge clk); #1;
      if (k == 5)  div_v[1] = 16'd10;
      if (k == 38) en[1] = 1'b0;
      @(negedge clk);
      if (pop[1]) begin np++; if (p2 < 0) p2 = k; end
      if (busy[1]) bc++;
    end
    chk("sb2_pop2_offset", 1, p2, 33);
    chk("sb2_extra_pops", 1, np, 1);
    chk("sb2_busy_len", 1, bc, 143);

    // Random traffic; the model checks every cycle.
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 9) < 2 && (wp[i] - rp[i]) < 200) push(i, 8'($urandom));
        if ($urandom_range(0, 19) == 0) en[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 29) == 0) div_v[i] = 16'($urandom_range(0, 5));
      end
    end

    // Drain both FIFOs.
    @(posedge clk); #1 en = 2'b11;
    ok = 0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (fifo_empty == 2'b11 && busy == 2'b00) begin ok = 1; break; end
    end
    chk("drain_done", 0, int'(ok), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
